// File: rtl/prog_ctr_pkg.sv
// Shared types and default parameters for the program counter block.
// Used by prog_ctr and prog_ctr_next.
package prog_ctr_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int START_ADDR_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STARTING = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

endpackage : prog_ctr_pkg

// File: rtl/prog_ctr_next.sv
// Combinational next-PC selection for prog_ctr. It picks restart, hold,
// absolute target, signed relative offset or increment.
module prog_ctr_next
    import prog_ctr_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF
) (
    input  state_e          state_i,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            abs_en_i,
    input  logic            rel_en_i,
    input  logic            alu_flag_i,
    input  logic [PC_W-1:0] target_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_o
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;

    // An unsigned add of the raw offset bits gives the same result as a signed add modulo 2^PC_W.
    assign pc_inc = pc_i + PC_W'(1);
    assign pc_rel = pc_i + target_i;

    // NOTE: pc_o gets a default before the case so no path leaves it unassigned, which avoids an inferred latch.
    always_comb begin
        pc_o = pc_i;
        unique case (state_i)
            ST_IDLE: begin
                if (start_i) pc_o = START_PC;
            end
            ST_STARTING: begin
                pc_o = START_PC;
            end
            ST_RUN: begin
                if (start_i)                      pc_o = START_PC;
                else if (halt_i)                  pc_o = pc_i;
                else if (abs_en_i)                pc_o = target_i;
                else if (rel_en_i && alu_flag_i)  pc_o = pc_rel;
                else                              pc_o = pc_inc;
            end
            default: begin
                pc_o = START_PC;
            end
        endcase
    end

endmodule : prog_ctr_next

// File: rtl/prog_ctr.sv
// Program counter with an IDLE / STARTING / RUN sequencer.
// Optional feature: define PROG_CTR_HALT_EN to add the Halt input, which freezes the PC while in RUN.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            BranchAbsEn,
    input  logic            BranchRelEn,
    input  logic            ALU_flag,
`ifdef PROG_CTR_HALT_EN
    input  logic            Halt,
`endif
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            halt;

`ifdef PROG_CTR_HALT_EN
    assign halt = Halt;
`else
    assign halt = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (Start) state_d = ST_STARTING;
            ST_STARTING: state_d = Start ? ST_STARTING : ST_RUN;
            ST_RUN:      if (Start) state_d = ST_STARTING;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Running is registered, so it is computed from the state being entered.
    always_comb begin
        running_d = (state_d == ST_RUN);
    end

    prog_ctr_next #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR)
    ) u_next (
        .state_i    (state_q),
        .start_i    (Start),
        .halt_i     (halt),
        .abs_en_i   (BranchAbsEn),
        .rel_en_i   (BranchRelEn),
        .alu_flag_i (ALU_flag),
        .target_i   (Target),
        .pc_i       (pc_q),
        .pc_o       (pc_d)
    );

    assign ProgCtr = pc_q;
    assign Running = running_q;

endmodule : prog_ctr

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr (PC_W=10, START_ADDR=0).
// Define PROG_CTR_HALT_EN to also exercise the Halt input.
module tb_prog_ctr;

    localparam int PC_W = 10;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            Start = 1'b0;
    logic            BranchAbsEn = 1'b0;
    logic            BranchRelEn = 1'b0;
    logic            ALU_flag = 1'b0;
    logic [PC_W-1:0] Target = '0;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
`ifdef PROG_CTR_HALT_EN
    logic            Halt = 1'b0;
`endif

    typedef struct {
        string           tag;
        logic [PC_W-1:0] pc;
        logic            run;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    prog_ctr #(.PC_W(PC_W), .START_ADDR(0)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .BranchAbsEn (BranchAbsEn),
        .BranchRelEn (BranchRelEn),
        .ALU_flag    (ALU_flag),
`ifdef PROG_CTR_HALT_EN
        .Halt        (Halt),
`endif
        .Target      (Target),
        .ProgCtr     (ProgCtr),
        .Running     (Running)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge result, then compare it after the edge.
    task automatic step(input string tag, input logic st, input logic ab, input logic re,
                        input logic fl, input logic [PC_W-1:0] tg,
                        input logic [PC_W-1:0] e_pc, input logic e_run);
        exp_t e;
        @(negedge Clk);
        Start = st; BranchAbsEn = ab; BranchRelEn = re; ALU_flag = fl; Target = tg;
        sb.push_back('{tag, e_pc, e_run});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".pc"}, 32'(ProgCtr), 32'(e.pc));
        check({e.tag, ".run"}, 32'(Running), 32'(e.run));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst.pc", 32'(ProgCtr), 32'd0);
        check("rst.run", 32'(Running), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        step("idle0",      0, 0, 0, 0, 10'd0,   10'd0,    0);
        step("idle1",      0, 0, 0, 0, 10'd0,   10'd0,    0);
        step("idle_abs",   0, 1, 0, 0, 10'd99,  10'd0,    0);
        step("start",      1, 0, 0, 0, 10'd0,   10'd0,    0);
        step("entry",      0, 0, 0, 0, 10'd0,   10'd0,    1);
        step("inc1",       0, 0, 0, 0, 10'd0,   10'd1,    1);
        step("abs10",      0, 1, 0, 0, 10'd10,  10'd10,   1);
        step("rel_nf",     0, 0, 1, 0, 10'd5,   10'd11,   1);
        step("rel_f",      0, 0, 1, 1, 10'd5,   10'd16,   1);
        step("rel_neg",    0, 0, 1, 1, 10'h3FC, 10'd12,   1);
        step("abs_max",    0, 1, 0, 0, 10'd1023, 10'd1023, 1);
        step("wrap",       0, 0, 0, 0, 10'd0,   10'd0,    1);
        step("inc_after",  0, 0, 0, 0, 10'd0,   10'd1,    1);
        step("abs_wins",   0, 1, 1, 1, 10'd7,   10'd7,    1);
        step("rel_wrap",   0, 0, 1, 1, 10'h3F0, 10'h3F7,  1);
        step("restart",    1, 0, 0, 0, 10'd0,   10'd0,    0);
        step("start_hold", 1, 1, 0, 0, 10'd55,  10'd0,    0);
        step("entry_br",   0, 1, 1, 1, 10'd55,  10'd0,    1);
        step("inc_again",  0, 0, 0, 0, 10'd0,   10'd1,    1);
        step("abs5",       0, 1, 0, 0, 10'd5,   10'd5,    1);

        // Asynchronous reset between edges must clear outputs without a clock.
        @(negedge Clk);
        BranchAbsEn = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        check("async.pc", 32'(ProgCtr), 32'd0);
        check("async.run", 32'(Running), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        step("post_rst0",  0, 0, 0, 0, 10'd0,   10'd0,    0);
        step("post_rst1",  0, 1, 0, 0, 10'd33,  10'd0,    0);

`ifdef PROG_CTR_HALT_EN
        step("h_start",    1, 0, 0, 0, 10'd0,   10'd0,    0);
        step("h_entry",    0, 0, 0, 0, 10'd0,   10'd0,    1);
        step("h_inc",      0, 0, 0, 0, 10'd0,   10'd1,    1);
        Halt = 1'b1;
        step("halt0",      0, 1, 0, 0, 10'd40,  10'd1,    1);
        step("halt1",      0, 0, 1, 1, 10'd40,  10'd1,    1);
        step("halt2",      0, 0, 0, 0, 10'd0,   10'd1,    1);
        step("halt_start", 1, 0, 0, 0, 10'd0,   10'd0,    0);
        Halt = 1'b0;
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prog_ctr

// File: doc/prog_ctr.md
PROG_CTR -- requirements
Module: prog_ctr

Interface
REQ-001 Parameter PC_W, default 10, program counter and Target width in bits.
REQ-002 Parameter START_ADDR, default 0, PC value loaded by reset and by each Start.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low (asserted at 0) reset.
REQ-005 Start  input  1  level request to (re)start at START_ADDR; level-sensitive.
REQ-006 BranchAbsEn  input  1  unconditional absolute branch enable.
REQ-007 BranchRelEn  input  1  relative branch enable; the branch is taken only when ALU_flag=1.
REQ-008 ALU_flag  input  1  branch condition from the ALU.
REQ-009 Target  input  PC_W  absolute target, or two's-complement relative offset.
REQ-010 ProgCtr  output  PC_W  registered index of the next instruction to fetch.
REQ-011 Running  output  1  registered; 1 only in state RUN.

Function
REQ-012 The block SHALL implement states IDLE, STARTING and RUN.
REQ-013 In IDLE: ProgCtr SHALL hold; Start=1 -> STARTING with ProgCtr<=START_ADDR.
REQ-014 In STARTING: ProgCtr SHALL equal START_ADDR; the state holds while Start=1; Start=0 -> RUN with ProgCtr<=START_ADDR (no increment on the entry edge).
REQ-015 In RUN, ProgCtr SHALL update every cycle using this priority: Start=1 -> STARTING with START_ADDR; else BranchAbsEn=1 -> Target; else BranchRelEn=1 and ALU_flag=1 -> ProgCtr+Target; else ProgCtr+1.
REQ-016 In RUN, BranchRelEn=1 with ALU_flag=0 SHALL produce ProgCtr+1.
REQ-017 Relative addition SHALL be modulo 2^PC_W, with Target treated as signed; ProgCtr+1 SHALL wrap from 2^PC_W-1 to 0.
REQ-018 BranchAbsEn and BranchRelEn SHALL be ignored outside RUN.
REQ-019 ProgCtr changes SHALL take effect one rising edge after the inputs are sampled; there is no combinational input-to-output path.

Reset
REQ-020 Reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, ProgCtr=START_ADDR and Running=0.
REQ-021 Reset asserted mid-RUN SHALL abandon execution; after release, the block stays in IDLE until Start.
REQ-022 Reset deassertion SHALL be synchronized by the integrating system; the block itself adds no synchronizer.

Configuration
REQ-023 Macro PROG_CTR_HALT_EN SHALL add a 1-bit input Halt.
REQ-024 With PROG_CTR_HALT_EN defined, Halt=1 in RUN SHALL freeze ProgCtr and ignore branches; Start keeps priority over Halt.
REQ-025 Without PROG_CTR_HALT_EN, the Halt port SHALL NOT exist and the behaviour is exactly REQ-012..REQ-019.

Structure
REQ-026 Package prog_ctr_pkg SHALL hold the state enum type, the PC_W default and the START_ADDR default.
REQ-027 The next-PC selection and adder SHALL be a combinational sub-module prog_ctr_next; the FSM and registers SHALL reside in prog_ctr.

Verification
REQ-028 Reset=0 with Clk toggling -> ProgCtr=0, Running=0; after Reset=1 with no Start, ProgCtr stays 0 for 2 cycles.
REQ-029 Start=1 for 1 cycle, then 0 -> ProgCtr=0 on the Start edge and on the entry edge, then 1 on the next edge, Running=1.
REQ-030 In RUN at ProgCtr=1 with BranchAbsEn=1, Target=10 -> ProgCtr=10; then BranchRelEn=1, Target=5, ALU_flag=0 -> 11; then ALU_flag=1 -> 16.
REQ-031 At ProgCtr=16 with BranchRelEn=1, ALU_flag=1, Target=10'h3FC (-4) -> 12; at ProgCtr=1023 with no branch -> 0.
REQ-032 BranchAbsEn=1 and BranchRelEn=1 together with ALU_flag=1, Target=7 -> 7 (absolute wins); Start=1 mid-RUN -> 0 and Running=0.
REQ-033 Reset=0 between clock edges mid-RUN -> ProgCtr=0 before the next edge; with PROG_CTR_HALT_EN and Halt=1 for 3 cycles -> ProgCtr constant.
